// File: rtl/tdm_pkg.sv
// Shared defaults, state encoding and slot offset helper for the TDM demux.
// Optional trailing parity slot is enabled by defining TDM_PARITY_EN.
package tdm_pkg;

  localparam int NUM_CH = 16;
  localparam int SEL_W  = 4;
  localparam int DATA_W = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PAR     = 2'd2
  } state_e;

  // Bit offset of slot k inside a packed frame word.
  function automatic int slot_off(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/demux_1x16.sv
// One-hot write-enable decoder for the shadow slots.
// Gated by en; inverse of the 16:1 slot mux.
module demux_1x16
  import tdm_pkg::*;
#(
  parameter int N_OUT = NUM_CH,
  parameter int SW    = SEL_W
) (
  input  logic [SW-1:0]    sel,
  input  logic             en,
  output logic [N_OUT-1:0] we
);

  // Decode the slot index into a single enable when gated on.
  always_comb begin
    we = '0;
    if (en) we[sel] = 1'b1;
  end

endmodule

// File: rtl/tdm_demux_16.sv
// 1-to-NUM_CH TDM demultiplexer publishing full frames as a parallel word.
// Define TDM_PARITY_EN to add a trailing even-parity slot and par_err.
module tdm_demux_16
  import tdm_pkg::*;
#(
  parameter int NUM_CH = tdm_pkg::NUM_CH,
  parameter int SEL_W  = tdm_pkg::SEL_W,
  parameter int DATA_W = tdm_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        din,
  input  logic                     din_vld,
  input  logic                     sof,
  output logic [NUM_CH*DATA_W-1:0] dout,
  output logic                     dout_vld,
  output logic [SEL_W-1:0]         slot,
`ifdef TDM_PARITY_EN
  output logic                     par_err,
`endif
  output logic                     err
);

  localparam int FW = NUM_CH * DATA_W;
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_CH - 1);
  localparam logic [SEL_W-1:0] ONE  = SEL_W'(1);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  slot_q, slot_d;
  logic [FW-1:0]     shadow_q, shadow_d;
  logic [FW-1:0]     dout_q, dout_d;
  logic              dout_vld_q, dout_vld_d;
  logic              err_q, err_d;
`ifdef TDM_PARITY_EN
  logic              par_err_q, par_err_d;
`endif

  logic [SEL_W-1:0]  wr_sel;
  logic              wr_en;
  logic [NUM_CH-1:0] wr_we;

  // sof always lands in slot 0; parity samples never touch the shadow.
  assign wr_sel = sof ? '0 : slot_q;
  assign wr_en  = din_vld & (sof | (state_q == COLLECT));

  demux_1x16 #(
    .N_OUT (NUM_CH),
    .SW    (SEL_W)
  ) u_dec (
    .sel (wr_sel),
    .en  (wr_en),
    .we  (wr_we)
  );

  // Shadow frame update from the decoded slot enables.
  always_comb begin
    shadow_d = shadow_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (wr_we[k])
        shadow_d[slot_off(k, DATA_W) +: DATA_W] = din;
    end
  end

  // Framing state machine: slot advance, publish and error pulses.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    err_d      = 1'b0;
`ifdef TDM_PARITY_EN
    par_err_d  = 1'b0;
`endif
    if (din_vld) begin
      case (state_q)
        IDLE: begin
          if (sof) begin
            slot_d  = ONE;
            state_d = COLLECT;
          end else begin
            err_d = 1'b1;
          end
        end
        COLLECT: begin
          if (sof) begin
            err_d  = 1'b1;
            slot_d = ONE;
          end else if (slot_q == LAST) begin
            slot_d = '0;
`ifdef TDM_PARITY_EN
            state_d = PAR;
`else
            dout_d     = shadow_d;
            dout_vld_d = 1'b1;
            state_d    = IDLE;
`endif
          end else begin
            slot_d = slot_q + ONE;
          end
        end
`ifdef TDM_PARITY_EN
        PAR: begin
          if (sof) begin
            err_d   = 1'b1;
            slot_d  = ONE;
            state_d = COLLECT;
          end else begin
            if ((^shadow_q ^ din[0]) == 1'b0) begin
              dout_d     = shadow_q;
              dout_vld_d = 1'b1;
            end else begin
              par_err_d = 1'b1;
            end
            state_d = IDLE;
          end
        end
`endif
        default: begin
          state_d = IDLE;
          slot_d  = '0;
        end
      endcase
    end
  end

  // Registered state and outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      shadow_q   <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
      err_q      <= 1'b0;
`ifdef TDM_PARITY_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      shadow_q   <= shadow_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
      err_q      <= err_d;
`ifdef TDM_PARITY_EN
      par_err_q  <= par_err_d;
`endif
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
  assign slot     = slot_q;
  assign err      = err_q;
`ifdef TDM_PARITY_EN
  assign par_err  = par_err_q;
`endif

endmodule

// File: tb/tb_tdm_demux_16.sv
// Scoreboard bench for tdm_demux_16: directed frames, gaps, restarts, reset.
// Covers the TDM_PARITY_EN build when that macro is defined.
module tb_tdm_demux_16;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:0]  din;
  logic        din_vld;
  logic        sof;
  logic [15:0] dout;
  logic        dout_vld;
  logic [3:0]  slot;
  logic        err;
`ifdef TDM_PARITY_EN
  logic        par_err;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int err_cnt = 0;
  int perr_cnt = 0;

  typedef struct {
    logic [15:0] word;
    int          at;
  } exp_t;
  exp_t sb[$];

  tdm_demux_16 dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .din_vld  (din_vld),
    .sof      (sof),
    .dout     (dout),
    .dout_vld (dout_vld),
    .slot     (slot),
`ifdef TDM_PARITY_EN
    .par_err  (par_err),
`endif
    .err      (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every dout_vld pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (err === 1'b1) err_cnt++;
`ifdef TDM_PARITY_EN
    if (par_err === 1'b1) perr_cnt++;
`endif
    if (dout_vld === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_dout_vld", {16'h0, dout}, 32'hDEAD_0000);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("dout", {16'h0, dout}, {16'h0, e.word});
        chk("vld_cycle", cyc, e.at);
      end
    end
  end

  task automatic sample(input logic d, input logic s);
    din     = d;
    sof     = s;
    din_vld = 1'b1;
    @(posedge clk);
    #1;
    din_vld = 1'b0;
    sof     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Send a 16-slot frame; optionally gaps after slots ga/gb, a restart
  // check on slot 0, a corrupted parity bit, and the publish expectation.
  task automatic send_frame(input logic [15:0] w, input int ga,
                            input int gb, input int glen,
                            input bit restart, input bit bad_par);
    for (int k = 0; k < 16; k++) begin
      sample(w[k], k == 0);
      if (k == 0 && restart)
        chk("restart_err", {31'h0, err}, 32'd1);
      if (k == ga || k == gb) begin
        idle(glen);
        chk("gap_slot", {28'h0, slot}, k + 1);
      end
    end
`ifdef TDM_PARITY_EN
    chk("par_no_early_vld", {31'h0, dout_vld}, 32'd0);
    sample((^w) ^ bad_par, 1'b0);
`endif
    if (!bad_par) sb.push_back('{w, cyc});
    chk("slot_wrap", {28'h0, slot}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    din = '0;
    din_vld = 1'b0;
    sof = 1'b0;
    idle(2);
    rst = 1'b0;
    chk("rst_dout", {16'h0, dout}, 32'h0);
    chk("rst_vld", {31'h0, dout_vld}, 32'd0);
    chk("rst_slot", {28'h0, slot}, 32'd0);
    chk("rst_err", {31'h0, err}, 32'd0);

    // Basic frame.
    send_frame(16'h8001, -1, -1, 0, 1'b0, 1'b0);
    idle(2);
    chk("basic_noerr", err_cnt, 0);

    // Gaps after slots 4 and 11.
    send_frame(16'hA5C3, 4, 11, 3, 1'b0, 1'b0);
    idle(2);

    // Early sof after 7 samples of a partial frame.
    for (int k = 0; k < 7; k++) sample(1'b1, k == 0);
    chk("partial_slot", {28'h0, slot}, 32'd7);
    send_frame(16'h00FF, -1, -1, 0, 1'b1, 1'b0);
    idle(2);
    chk("early_err_cnt", err_cnt, 1);

    // Back-to-back frames.
    send_frame(16'h1234, -1, -1, 0, 1'b0, 1'b0);
    send_frame(16'hFFFF, -1, -1, 0, 1'b0, 1'b0);
    idle(2);
    chk("dout_hold", {16'h0, dout}, 32'hFFFF);

    // Stray sample with no sof while idle.
    sample(1'b1, 1'b0);
    chk("stray_err", {31'h0, err}, 32'd1);
    idle(1);
    chk("stray_err_cnt", err_cnt, 2);

    // Mid-frame reset.
    for (int k = 0; k < 9; k++) sample(1'b1, k == 0);
    chk("mid_slot", {28'h0, slot}, 32'd9);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("mid_rst_dout", {16'h0, dout}, 32'h0);
    chk("mid_rst_vld", {31'h0, dout_vld}, 32'd0);
    chk("mid_rst_slot", {28'h0, slot}, 32'd0);
    send_frame(16'h0F0F, -1, -1, 0, 1'b0, 1'b0);
    idle(2);

`ifdef TDM_PARITY_EN
    send_frame(16'h0003, -1, -1, 0, 1'b0, 1'b0);
    idle(2);
    send_frame(16'h0003, -1, -1, 0, 1'b0, 1'b1);
    idle(2);
    chk("par_err_cnt", perr_cnt, 1);
    chk("par_dout_hold", {16'h0, dout}, 32'h0003);
`endif

    chk("sb_drained", sb.size(), 0);
    chk("final_err_cnt", err_cnt, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdm_demux_16.md
Name: tdm_demux_16

Overview:
Sequential 1-to-NUM_CH time-division demultiplexer; the receive-side counterpart of the 16:1 mux datapath. Accepts one DATA_W-bit sample per valid cycle. A start-of-frame marker aligns sample k to channel k. Each complete frame is published as one parallel word with a one-cycle valid pulse. Sits between a serial/TDM link and parallel per-channel logic.

Parameters:
NUM_CH, 16, number of channels (slots) per frame; power of 2, minimum 2.
SEL_W, 4, slot counter width; equals log2(NUM_CH).
DATA_W, 1, bits per slot sample.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
din  input  DATA_W  slot sample
din_vld  input  1  din valid this cycle; sample accepted on the rising edge when high
sof  input  1  start of frame; qualified by din_vld; marks the slot-0 sample
dout  output  NUM_CH*DATA_W  last complete frame; slot k occupies dout[k*DATA_W +: DATA_W]
dout_vld  output  1  one-cycle pulse; dout updated this cycle
slot  output  SEL_W  index the next accepted sample is written to
err  output  1  one-cycle pulse on framing error

Behaviour:
- Clock, reset and encoding:
  - One clock: clk. Reset rst is synchronous and active-high.
  - Reset clears state to IDLE, and sets slot=0, shadow=0, dout=0, dout_vld=0, err=0. Any partial frame is discarded.
  - All outputs are registered.
- States: IDLE, COLLECT (PAR is added with the optional feature).
- IDLE:
  - din_vld=1 and sof=1: write din to shadow slot 0; slot<=1; go to COLLECT.
  - din_vld=1 and sof=0: sample dropped; err pulses.
  - din_vld=0: no action.
- COLLECT:
  - din_vld=0: stall; slot, shadow and state hold. Gaps of any length are allowed.
  - din_vld=1 and sof=0: write shadow[slot]; slot<=slot+1.
- Last slot (din_vld=1, sof=0, slot==NUM_CH-1), all on the same edge:
  - dout <= shadow merged with din in the top slot.
  - dout_vld <= 1.
  - slot <= 0 (wrap); state <= IDLE.
  - Latency: dout and dout_vld are visible in the cycle after the edge that accepts the last sample.
- sof with din_vld=1 in COLLECT (early or restarted frame):
  - err pulses; the partial frame is discarded and dout is unchanged.
  - din is written to slot 0; slot<=1; stay in COLLECT.
- sof with din_vld=0 is ignored in every state.
- Back-to-back frames: sof on the cycle after the last slot is accepted from IDLE with no bubble. This gives one frame per NUM_CH valid cycles.
- dout holds its value until the next complete frame. dout_vld is never high for two consecutive cycles.
- The shadow register is never cleared between frames. Every slot is overwritten before publish.

Optional Feature:
Macro: TDM_PARITY_EN.
- Defined:
  - Each frame carries one extra trailing sample. din[0] is the even-parity bit over all NUM_CH*DATA_W data bits.
  - After the last data slot is accepted, go to PAR; dout is not yet updated.
  - In PAR, din_vld=1 and sof=0: if XOR(shadow) ^ din[0] == 0, publish dout and pulse dout_vld. Otherwise add output port par_err (1 bit) and pulse it with dout unchanged. Either way, go to IDLE.
  - sof in PAR: same restart/err rule as in COLLECT.
  - par_err resets to 0.
- Undefined: no PAR state, no par_err port, behaviour exactly as above.

Decomposition:
- Package tdm_pkg holds:
  - NUM_CH, SEL_W, DATA_W defaults.
  - State enum: IDLE, COLLECT, PAR.
  - Function for the slot-k bit offset.
- One sub-module, demux_1x16: combinational SEL_W-to-NUM_CH one-hot write-enable decoder. It is gated by din_vld and drives shadow slot enables; it is the inverse of mux_16x1.

Test Plan:
- Basic frame: rst for 2 cycles. Then sof=1 with din=1, then 14 samples of 0, then din=1 (bits of 16'h8001, LSB first, continuous din_vld). Required: dout=16'h8001, dout_vld high exactly one cycle after the 16th sample; slot returns to 0.
- Gaps: same frame as 16'hA5C3 with din_vld low for 3 cycles after slots 4 and 11. Required: dout=16'hA5C3, one dout_vld pulse; slot holds during gaps.
- Early sof: send 7 samples, then sof with a full 16'h00FF frame. Required: err pulse at the restart edge; dout=16'h00FF only after 16 further samples; previous dout held meanwhile.
- Back-to-back: frames 16'h1234 then 16'hFFFF with no idle cycle. Required: two dout_vld pulses 16 cycles apart, with dout=16'h1234 then 16'hFFFF.
- Mid-frame reset: assert rst after 9 samples, then send a full 16'h0F0F frame. Required: dout=0 with dout_vld=0 after reset; next dout=16'h0F0F.
- TDM_PARITY_EN: frame 16'h0003 with parity 0, then 16'h0003 with parity 1. Required: first publishes with dout_vld; second pulses par_err, dout stays 16'h0003, dout_vld stays 0.
